// File: rtl/mma8452q_pkg.sv
// mma8452q_pkg: shared encodings for the MMA8452Q transaction sequencer.
//   - cmd_op_e : command opcodes understood by the byte-level I2C engine
//   - state_e  : sequencer FSM states
//   - register addresses and step indices of the command scripts
package mma8452q_pkg;

    typedef enum logic [2:0] {
        CMD_START     = 3'd0,
        CMD_RSTART    = 3'd1,
        CMD_WRITE     = 3'd2,
        CMD_READ_ACK  = 3'd3,
        CMD_READ_NACK = 3'd4,
        CMD_STOP      = 3'd5
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CFG     = 3'd1,
        ST_RD      = 3'd2,
        ST_PUBLISH = 3'd3,
        ST_WAIT    = 3'd4
    } state_e;

    localparam logic [7:0] REG_OUT_X_MSB = 8'h01;
    localparam logic [7:0] REG_CTRL_REG1 = 8'h2A;

    // Step indices inside the CFG and RD command scripts.
    localparam logic [3:0] CFG_STOP_STEP = 4'd4;
    localparam logic [3:0] RD_FIRST_BYTE = 4'd5;
    localparam logic [3:0] RD_NACK_STEP  = 4'd10;
    localparam logic [3:0] RD_STOP_STEP  = 4'd11;

endpackage

// File: rtl/i2c_cmd_issuer.sv
// i2c_cmd_issuer: keeps one I2C engine command in flight.
//   issue/op/data  : request from the sequencer (ignored while busy)
//   cmd_*          : command channel to the engine; op/data frozen once valid
//   rsp_valid      : engine completion pulse; only counted while a command
//                    has been accepted and is awaiting its response
//   busy           : a command is being offered or awaits its response
//   done           : response for the outstanding command arrived this cycle
module i2c_cmd_issuer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue,
    input  logic [2:0] op,
    input  logic [7:0] data,
    input  logic       cmd_ready,
    input  logic       rsp_valid,
    output logic       cmd_valid,
    output logic [2:0] cmd_op,
    output logic [7:0] cmd_data,
    output logic       busy,
    output logic       done
);

    logic       hold_q, hold_d;
    logic       pend_q, pend_d;
    logic [2:0] op_q, op_d;
    logic [7:0] data_q, data_d;
    logic       accept;

    always_comb begin
        // A fresh request is presented in the same cycle it is issued, so
        // cmd_valid rises in the state that owns the command.
        cmd_valid = hold_q | (issue & ~pend_q);
        cmd_op    = hold_q ? op_q   : op;
        cmd_data  = hold_q ? data_q : data;
        accept    = cmd_valid & cmd_ready;
        done      = rsp_valid & pend_q;
        busy      = hold_q | pend_q;

        hold_d = hold_q;
        pend_d = pend_q;
        op_d   = op_q;
        data_d = data_q;
        if (accept) begin
            hold_d = 1'b0;
            pend_d = 1'b1;
        end else begin
            if (cmd_valid && !hold_q) begin
                hold_d = 1'b1;
                op_d   = op;
                data_d = data;
            end
            if (done) pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 1'b0;
            pend_q <= 1'b0;
            op_q   <= 3'd0;
            data_q <= 8'd0;
        end else begin
            hold_q <= hold_d;
            pend_q <= pend_d;
            op_q   <= op_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/mma8452q_sequencer.sv
// mma8452q_sequencer: configures the MMA8452Q once, then polls the six
// output registers in a burst every POLL_CYCLES and publishes X/Y/Z.
//   enable              : run; low returns to IDLE at a transaction boundary
//   cmd_* / rsp_*       : command/response handshake with the I2C engine
//   acel_x/y/z          : 12-bit two's complement samples
//   sample_valid        : one-cycle pulse when acel_* update
//   busy                : high outside IDLE and WAIT
//   err                 : sticky give-up flag after repeated NACKs
module mma8452q_sequencer
    import mma8452q_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'h1D,
    parameter logic [7:0]  CFG_REG     = REG_CTRL_REG1,
    parameter logic [7:0]  CFG_VAL     = 8'h01,
    parameter logic [7:0]  DATA_REG    = REG_OUT_X_MSB,
    parameter int unsigned POLL_CYCLES = 50000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_op,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic        rsp_nack,
    input  logic [7:0]  rsp_data,
    output logic [11:0] acel_x,
    output logic [11:0] acel_y,
    output logic [11:0] acel_z,
    output logic        sample_valid,
    output logic        busy,
    output logic        err
);

    localparam int unsigned P_EFF = (POLL_CYCLES == 0) ? 1 : POLL_CYCLES;
    localparam int unsigned CNT_W = $clog2(P_EFF + 1);
    localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;      // phase to resume after WAIT
    logic [3:0]         step_q, step_d;
    logic               abort_q, abort_d;  // NACK seen, finishing with STOP
    logic               err_q, err_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0][7:0]    shadow_q, shadow_d;
    logic [11:0]        ax_q, ax_d, ay_q, ay_d, az_q, az_d;
    logic               sv_q, sv_d;
    logic               busy_q, busy_d;

    cmd_op_e            cur_op;
    logic [7:0]         cur_data;
    logic               issue, iss_busy, iss_done;

    i2c_cmd_issuer u_issuer (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (issue),
        .op        (cur_op),
        .data      (cur_data),
        .cmd_ready (cmd_ready),
        .rsp_valid (rsp_valid),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .busy      (iss_busy),
        .done      (iss_done)
    );

    // Command scripts: the current step selects the op/byte to offer.
    always_comb begin
        cur_op   = CMD_START;
        cur_data = 8'd0;
        if (state_q == ST_CFG) begin
            case (step_q)
                4'd0:    cur_op = CMD_START;
                4'd1:    begin cur_op = CMD_WRITE; cur_data = {DEV_ADDR, 1'b0}; end
                4'd2:    begin cur_op = CMD_WRITE; cur_data = CFG_REG; end
                4'd3:    begin cur_op = CMD_WRITE; cur_data = CFG_VAL; end
                default: cur_op = CMD_STOP;
            endcase
        end else if (state_q == ST_RD) begin
            case (step_q)
                4'd0:    cur_op = CMD_START;
                4'd1:    begin cur_op = CMD_WRITE; cur_data = {DEV_ADDR, 1'b0}; end
                4'd2:    begin cur_op = CMD_WRITE; cur_data = DATA_REG; end
                4'd3:    cur_op = CMD_RSTART;
                4'd4:    begin cur_op = CMD_WRITE; cur_data = {DEV_ADDR, 1'b1}; end
                4'd5, 4'd6, 4'd7, 4'd8, 4'd9: cur_op = CMD_READ_ACK;
                RD_NACK_STEP: cur_op = CMD_READ_NACK;
                default: cur_op = CMD_STOP;
            endcase
        end
        issue = ((state_q == ST_CFG) || (state_q == ST_RD)) && !iss_busy;
    end

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        step_d   = step_q;
        abort_d  = abort_q;
        err_d    = err_q;
        retry_d  = retry_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;

        case (state_q)
            ST_IDLE: begin
                if (!enable) begin
                    err_d   = 1'b0;
                    retry_d = '0;
                end else if (!err_q) begin
                    state_d = ST_CFG;
                    step_d  = 4'd0;
                    ret_d   = ST_RD;
                end
            end
            ST_CFG, ST_RD: begin
                if (iss_done) begin
                    if (cur_op == CMD_STOP) begin
                        // Transaction boundary: the only place enable is sampled.
                        step_d = 4'd0;
                        if (abort_q) begin
                            abort_d = 1'b0;
                            if (err_q) begin
                                state_d = ST_IDLE;
                            end else begin
                                retry_d = retry_q + 1'b1;
                                ret_d   = state_q;
                                state_d = enable ? ST_WAIT : ST_IDLE;
                            end
                        end else if (state_q == ST_CFG) begin
                            state_d = enable ? ST_RD : ST_IDLE;
                        end else begin
                            state_d = ST_PUBLISH;
                        end
                    end else if (cur_op == CMD_WRITE && rsp_nack) begin
                        abort_d = 1'b1;
                        step_d  = (state_q == ST_CFG) ? CFG_STOP_STEP : RD_STOP_STEP;
                        if (retry_q == RTY_W'(MAX_RETRY)) err_d = 1'b1;
                    end else begin
                        if (state_q == ST_RD) begin
                            for (int k = 0; k < 6; k++) begin
                                if (step_q == RD_FIRST_BYTE + 4'(k)) shadow_d[k] = rsp_data;
                            end
                        end
                        step_d = step_q + 4'd1;
                    end
                end
            end
            ST_PUBLISH: begin
                retry_d = '0;
                ret_d   = ST_RD;
                step_d  = 4'd0;
                state_d = enable ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(P_EFF - 1)) begin
                    state_d = ret_q;
                    step_d  = 4'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_WAIT && state_q != ST_WAIT) cnt_d = '0;

        // Outputs are registered off the next state so they line up with it.
        busy_d = !(state_d == ST_IDLE || state_d == ST_WAIT);
        sv_d   = (state_d == ST_PUBLISH);
        ax_d   = ax_q;
        ay_d   = ay_q;
        az_d   = az_q;
        if (state_d == ST_PUBLISH) begin
            ax_d = {shadow_q[0], shadow_q[1][7:4]};
            ay_d = {shadow_q[2], shadow_q[3][7:4]};
            az_d = {shadow_q[4], shadow_q[5][7:4]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ret_q    <= ST_RD;
            step_q   <= 4'd0;
            abort_q  <= 1'b0;
            err_q    <= 1'b0;
            retry_q  <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            ax_q     <= 12'd0;
            ay_q     <= 12'd0;
            az_q     <= 12'd0;
            sv_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            step_q   <= step_d;
            abort_q  <= abort_d;
            err_q    <= err_d;
            retry_q  <= retry_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            ax_q     <= ax_d;
            ay_q     <= ay_d;
            az_q     <= az_d;
            sv_q     <= sv_d;
            busy_q   <= busy_d;
        end
    end

    assign acel_x       = ax_q;
    assign acel_y       = ay_q;
    assign acel_z       = az_q;
    assign sample_valid = sv_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule

// File: tb/tb_mma8452q_sequencer.sv
module tb_mma8452q_sequencer;

    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic        cmd_ready = 1'b1, rsp_valid = 1'b0, rsp_nack = 1'b0;
    logic [7:0]  rsp_data = 8'd0;
    logic        cmd_valid, sample_valid, busy, err;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic [11:0] acel_x, acel_y, acel_z;

    mma8452q_sequencer #(.POLL_CYCLES(100), .MAX_RETRY(3)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_data(rsp_data),
        .acel_x(acel_x), .acel_y(acel_y), .acel_z(acel_z),
        .sample_valid(sample_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0, cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] ent(input logic [2:0] op, input logic [7:0] d);
        return {op, d};
    endfunction

    // ---------------- engine model ----------------
    logic [10:0] log_q[$];
    logic [7:0]  rd_b[6];
    int          pend = 0, stall = 0, nack_cnt = 0, rd_idx = 0, stop_cyc = 0;
    bit          stall_arm = 1'b0, p_nack = 1'b0;
    logic [2:0]  p_op = 3'd0;
    logic [7:0]  p_data = 8'd0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'd0;
            pend = 0; stall = 0; cmd_ready = 1'b1;
        end else begin
            rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'd0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    rsp_valid = 1'b1; rsp_nack = p_nack; rsp_data = p_data;
                    if (p_op == 3'd5) stop_cyc = cyc;
                end
            end
            if (stall_arm && cmd_valid && cmd_op == 3'd2) begin
                stall = 20; stall_arm = 1'b0;
            end
            if (stall > 0) begin cmd_ready = 1'b0; stall--; end
            else cmd_ready = 1'b1;
            if (cmd_valid && cmd_ready) begin
                log_q.push_back({cmd_op, cmd_data});
                p_op = cmd_op; pend = 2; p_nack = 1'b0; p_data = 8'd0;
                if (cmd_op == 3'd0) rd_idx = 0;
                if (cmd_op == 3'd2 && cmd_data == 8'h3A && nack_cnt > 0) begin
                    p_nack = 1'b1; nack_cnt--;
                end
                if (cmd_op == 3'd3 || cmd_op == 3'd4) begin
                    p_data = rd_b[rd_idx % 6]; rd_idx++;
                end
            end
        end
    end

    // ---------------- monitors ----------------
    int   sv_cnt = 0, sv_cyc = 0, cv_cnt = 0, idle_cyc = 0, cv_rise = 0;
    logic busy_prev = 1'b0, cv_prev = 1'b0;
    always @(negedge clk) begin
        if (sample_valid) begin sv_cnt++; sv_cyc = cyc; end
        if (cmd_valid) cv_cnt++;
        if (busy_prev && !busy) idle_cyc = cyc;
        if (!cv_prev && cmd_valid) cv_rise = cyc;
        busy_prev = busy; cv_prev = cmd_valid;
    end

    task automatic wait_log(input int n, input int budget, input string tag);
        int k = 0;
        while (log_q.size() < n && k < budget) begin @(negedge clk); k++; end
        chk(tag, 32'(log_q.size() >= n), 1);
    endtask

    task automatic wait_sv(input int n, input int budget, input string tag);
        int k = 0;
        while (sv_cnt < n && k < budget) begin @(negedge clk); k++; end
        chk(tag, 32'(sv_cnt >= n), 1);
    endtask

    logic [10:0] exp_cfg[5];
    logic [10:0] exp_rd[12];
    logic [10:0] exp_nk[8];

    initial begin
        int mark, bad, k, c0, starts, sv0;
        exp_cfg = '{ent(0,0), ent(2,8'h3A), ent(2,8'h2A), ent(2,8'h01), ent(5,0)};
        exp_rd  = '{ent(0,0), ent(2,8'h3A), ent(2,8'h01), ent(1,0), ent(2,8'h3B),
                    ent(3,0), ent(3,0), ent(3,0), ent(3,0), ent(3,0), ent(4,0), ent(5,0)};
        exp_nk  = '{ent(0,0), ent(2,8'h3A), ent(5,0),
                    ent(0,0), ent(2,8'h3A), ent(2,8'h2A), ent(2,8'h01), ent(5,0)};
        rd_b = '{8'h12, 8'h30, 8'hF0, 8'h10, 8'h00, 8'hA0};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_sv", 32'(sample_valid), 0);
        chk("rst_acel_x", 32'(acel_x), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        // configuration
        enable = 1'b1;
        wait_log(2, 100, "cfg_start");
        chk("cfg_busy", 32'(busy), 1);
        wait_log(5, 200, "cfg_done");
        for (int i = 0; i < 5; i++) chk($sformatf("cfg[%0d]", i), 32'(log_q[i]), 32'(exp_cfg[i]));
        chk("cfg_busy_end", 32'(busy), 1);

        // first burst
        wait_sv(1, 500, "rd1_sv");
        for (int i = 0; i < 12; i++) chk($sformatf("rd1[%0d]", i), 32'(log_q[5+i]), 32'(exp_rd[i]));
        chk("rd1_x", 32'(acel_x), 32'h123);
        chk("rd1_y", 32'(acel_y), 32'hF01);
        chk("rd1_z", 32'(acel_z), 32'h00A);
        chk("sv_latency", 32'(sv_cyc - stop_cyc), 1);
        rd_b = '{8'h7F, 8'hF0, 8'h80, 8'h00, 8'hFF, 8'hF0};
        repeat (5) @(negedge clk);
        chk("sv_once", 32'(sv_cnt), 1);

        // poll interval
        k = 0;
        while (cv_rise <= sv_cyc && k < 400) begin @(negedge clk); k++; end
        chk("poll_gap", 32'(cv_rise - idle_cyc), 100);

        // second burst: extreme values
        wait_sv(2, 500, "rd2_sv");
        chk("rd2_x", 32'(acel_x), 32'h7FF);
        chk("rd2_y", 32'(acel_y), 32'h800);
        chk("rd2_z", 32'(acel_z), 32'hFFF);
        rd_b = '{8'h01, 8'h20, 8'h02, 8'h30, 8'h03, 8'h40};

        // enable dropped during byte 3 of the third burst
        wait_log(38, 500, "rd3_byte3");
        enable = 1'b0;
        wait_sv(3, 200, "rd3_sv");
        chk("rd3_x", 32'(acel_x), 32'h012);
        chk("rd3_y", 32'(acel_y), 32'h023);
        chk("rd3_z", 32'(acel_z), 32'h034);
        repeat (5) @(negedge clk);
        chk("rd3_log_len", 32'(log_q.size()), 41);
        chk("rd3_nack", 32'(log_q[39]), 32'(ent(4,0)));
        chk("rd3_stop", 32'(log_q[40]), 32'(ent(5,0)));
        c0 = cv_cnt;
        repeat (300) @(negedge clk);
        chk("idle_no_cmd", 32'(cv_cnt - c0), 0);
        chk("idle_busy2", 32'(busy), 0);

        // cmd_ready stall on a WRITE
        mark = log_q.size();
        stall_arm = 1'b1;
        enable = 1'b1;
        k = 0;
        while (!(cmd_valid && cmd_op == 3'd2) && k < 100) begin @(negedge clk); k++; end
        chk("stall_seen", 32'(cmd_valid && cmd_op == 3'd2), 1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_valid !== 1'b1 || cmd_op !== 3'd2 || cmd_data !== 8'h3A) bad++;
        end
        chk("stall_hold", 32'(bad), 0);
        wait_log(mark + 2, 50, "stall_accept");
        chk("stall_entry", 32'(log_q[mark+1]), 32'(ent(2,8'h3A)));

        // reset in the middle of a read
        wait_log(mark + 12, 500, "rst_mid_rd");
        @(negedge clk);
        #2 rst_n = 1'b0; enable = 1'b0;
        #1;
        chk("mrst_cmd_valid", 32'(cmd_valid), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_acel_x", 32'(acel_x), 0);
        chk("mrst_acel_y", 32'(acel_y), 0);
        chk("mrst_acel_z", 32'(acel_z), 0);
        chk("mrst_op_data", 32'({cmd_op, cmd_data}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single NACK then retry
        nack_cnt = 1;
        mark = log_q.size();
        sv0 = sv_cnt;
        enable = 1'b1;
        wait_log(mark + 8, 1000, "nack_retry");
        for (int i = 0; i < 8; i++) chk($sformatf("nk[%0d]", i), 32'(log_q[mark+i]), 32'(exp_nk[i]));
        chk("nack_err", 32'(err), 0);
        wait_sv(sv0 + 1, 1000, "nack_rd_sv");
        chk("nack_err2", 32'(err), 0);

        // persistent NACK
        enable = 1'b0;
        repeat (5) @(negedge clk);
        nack_cnt = 1000;
        mark = log_q.size();
        enable = 1'b1;
        k = 0;
        while (err !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
        chk("pers_err", 32'(err), 1);
        k = 0;
        while (busy !== 1'b0 && k < 100) begin @(negedge clk); k++; end
        repeat (10) @(negedge clk);
        chk("pers_log_len", 32'(log_q.size() - mark), 12);
        starts = 0;
        for (int i = mark; i < log_q.size(); i++) if (log_q[i] == ent(0,0)) starts++;
        chk("pers_attempts", 32'(starts), 4);
        chk("pers_last_stop", 32'(log_q[mark+11]), 32'(ent(5,0)));
        c0 = cv_cnt;
        repeat (300) @(negedge clk);
        chk("pers_no_cmd", 32'(cv_cnt - c0), 0);
        chk("pers_busy", 32'(busy), 0);
        chk("pers_err_hold", 32'(err), 1);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("err_clear", 32'(err), 0);
        nack_cnt = 0;
        mark = log_q.size();
        enable = 1'b1;
        wait_log(mark + 1, 50, "restart");
        chk("restart_start", 32'(log_q[mark]), 32'(ent(0,0)));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
